// File: rtl/seg_disp_pkg.sv
// Shared types, segment constants and the BCD-to-segment lookup for the
// multiplexed 7-segment display driver (active-low gfedcba encoding).
package seg_disp_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0] digit_t;

    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Codes 10..15 are not valid BCD and show a dash instead of garbage.
    function automatic logic [6:0] bcd_to_seg(input digit_t digit);
        if (digit <= 4'd9) begin
            return SEG_LUT[digit];
        end
        return SEG_DASH;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit decoder producing active-low {g,f,e,d,c,b,a}.
module bcd_to_7seg
    import seg_disp_pkg::*;
(
    input  digit_t     digit,
    output logic [6:0] seg
);

    assign seg = bcd_to_seg(digit);

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit common-anode scan driver with per-slot guard time and
// frame-aligned double buffering. Optional LEAD_ZERO_BLANK_EN suppresses leading zeros.
module seg_scan_driver
    import seg_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD_CYC   = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic [3:0] thousands,
    input  logic       blank,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       pending,
    output logic       frame_tick
);

    localparam int              CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYC);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic             commit;
    logic             in_guard;
    digit_t           in_digits  [NUM_DIGITS];
    digit_t           pend_regs  [NUM_DIGITS];
    digit_t           shadow     [NUM_DIGITS];
    digit_t           cur_digit;
    logic [6:0]       dec_seg;
    logic             digit_off;
    logic [3:0]       an_next;
    logic [6:0]       seg_next;
    logic [3:0]       an_r;
    logic [6:0]       seg_r;
    logic             pending_r;
    logic             frame_tick_r;

    always_comb begin
        in_digits[0] = ones;
        in_digits[1] = tens;
        in_digits[2] = hundreds;
        in_digits[3] = thousands;
    end

    assign commit   = (idx == 2'd3) && (cnt == CNT_LAST);
    assign in_guard = (cnt < GUARD_END);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Shadow only changes at the frame boundary so a count never tears;
    // a load landing on the boundary itself goes straight to the shadow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                pend_regs[i] <= '0;
                shadow[i]    <= '0;
            end
            pending_r    <= 1'b0;
            frame_tick_r <= 1'b0;
        end else begin
            frame_tick_r <= commit;
            if (load) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    pend_regs[i] <= in_digits[i];
                end
            end
            if (commit) begin
                pending_r <= 1'b0;
                if (load) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        shadow[i] <= in_digits[i];
                    end
                end else if (pending_r) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        shadow[i] <= pend_regs[i];
                    end
                end
            end else if (load) begin
                pending_r <= 1'b1;
            end
        end
    end

    assign cur_digit = shadow[idx];

    bcd_to_7seg u_dec (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

`ifdef LEAD_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lead_zero;

    // Ones digit is never suppressed; invalid codes count as non-zero.
    always_comb begin
        lead_zero    = '0;
        lead_zero[3] = (shadow[3] == 4'd0);
        lead_zero[2] = (shadow[3] == 4'd0) && (shadow[2] == 4'd0);
        lead_zero[1] = (shadow[3] == 4'd0) && (shadow[2] == 4'd0) && (shadow[1] == 4'd0);
    end

    assign digit_off = lead_zero[idx];
`else
    assign digit_off = 1'b0;
`endif

    always_comb begin
        an_next  = 4'hF;
        seg_next = SEG_OFF;
        if (!in_guard) begin
            seg_next = dec_seg;
            if (!blank && !digit_off) begin
                an_next = ~(4'b0001 << idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_r  <= 4'hF;
            seg_r <= SEG_OFF;
        end else begin
            an_r  <= an_next;
            seg_r <= seg_next;
        end
    end

    assign an         = an_r;
    assign seg        = seg_r;
    assign dp         = 1'b1;
    assign pending    = pending_r;
    assign frame_tick = frame_tick_r;

endmodule
